// File: rtl/popcount_pkg.sv
// popcount_pkg -- shared types and helpers for the popcount_engine block.
//   pc_state_t : engine FSM states (idle, counting slices, result held)
//   cnt_width  : width needed to hold a count of 0..data_w set bits
package popcount_pkg;

   typedef enum logic [1:0] {
      PC_IDLE  = 2'd0,
      PC_COUNT = 2'd1,
      PC_DONE  = 2'd2
   } pc_state_t;

   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/popcount_slice.sv
// popcount_slice -- combinational population count of one SLICE_W-bit slice.
// Ports:
//   bits : slice to count (SLICE_W bits)
//   ones : number of set bits in bits ($clog2(SLICE_W+1) bits)
module popcount_slice #(
   parameter int SLICE_W = 8,
   parameter int SUM_W   = $clog2(SLICE_W + 1)
) (
   input  logic [SLICE_W-1:0] bits,
   output logic [SUM_W-1:0]   ones
);

   // Straight sum of the bits; synthesis balances this into an adder tree.
   always_comb begin
      ones = '0;
      for (int i = 0; i < SLICE_W; i++) begin
         ones = ones + SUM_W'(bits[i]);
      end
   end

endmodule

// File: rtl/popcount_engine.sv
// popcount_engine -- multi-cycle population count / Hamming distance engine.
// Takes a DATA_W-bit operand over a valid/ready handshake, counts SLICE_W bits
// per cycle, and presents the result on a second valid/ready handshake with
// backpressure. A new operand can be accepted in the same cycle the previous
// result is transferred.
// Optional build macro: POPCOUNT_EARLY_EXIT_EN -- finish as soon as the
// remaining (unshifted) operand bits are all zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_vld     : operand valid          in_rdy    : engine can accept
//   in_mode    : 0 = popcount(in_data), 1 = popcount(in_data ^ in_ref)
//   in_data    : operand                in_ref    : reference word
//   out_vld    : result valid           out_rdy   : consumer accepts result
//   out_count  : result (CNT_W bits)
module popcount_engine
   import popcount_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int SLICE_W = 8,
   parameter int CNT_W   = cnt_width(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic              in_mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_ref,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [CNT_W-1:0]  out_count
);

   localparam int N     = DATA_W / SLICE_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int SUM_W = $clog2(SLICE_W + 1);

   generate
      if (DATA_W % SLICE_W != 0) begin : g_bad_width
         $error("popcount_engine: DATA_W must be a multiple of SLICE_W");
      end
   endgenerate

   pc_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] op;
   logic [IDX_W-1:0]  idx;
   logic [CNT_W-1:0]  count;
   logic [SUM_W-1:0]  slice_ones;
   logic              accept;
   logic              last_slice;

   // in_rdy follows out_rdy combinationally in DONE so a result transfer and
   // the next accept can share one cycle.
   assign in_rdy    = (state == PC_IDLE) | ((state == PC_DONE) & out_rdy);
   assign accept    = in_vld & in_rdy;
   assign op        = in_mode ? (in_data ^ in_ref) : in_data;
   assign shifted   = shreg >> SLICE_W;
   assign out_vld   = (state == PC_DONE);
   assign out_count = count;

`ifdef POPCOUNT_EARLY_EXIT_EN
   // Nothing left to count once the remaining bits are all zero.
   assign last_slice = (idx == IDX_W'(N - 1)) | (shifted == '0);
`else
   assign last_slice = (idx == IDX_W'(N - 1));
`endif

   popcount_slice #(
      .SLICE_W (SLICE_W),
      .SUM_W   (SUM_W)
   ) u_slice (
      .bits (shreg[SLICE_W-1:0]),
      .ones (slice_ones)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PC_IDLE;
         shreg <= '0;
         idx   <= '0;
         count <= '0;
      end else if (accept) begin
         // Mode and reference are captured here only; later changes are ignored.
         state <= PC_COUNT;
         shreg <= op;
         idx   <= '0;
         count <= '0;
      end else begin
         case (state)
            PC_COUNT: begin
               count <= count + CNT_W'(slice_ones);
               shreg <= shifted;
               idx   <= idx + IDX_W'(1);
               if (last_slice) begin
                  state <= PC_DONE;
               end
            end
            PC_DONE: begin
               if (out_rdy) begin
                  state <= PC_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_engine.sv
// tb_popcount_engine -- directed self-checking bench for popcount_engine.
// Build with or without POPCOUNT_EARLY_EXIT_EN; expected latencies adapt.
module tb_popcount_engine;

   localparam int DATA_W  = 64;
   localparam int SLICE_W = 8;
   localparam int CNT_W   = 7;
   localparam int N       = DATA_W / SLICE_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_vld;
   logic              in_rdy;
   logic              in_mode;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] in_ref;
   logic              out_vld;
   logic              out_rdy;
   logic [CNT_W-1:0]  out_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   popcount_engine #(
      .DATA_W  (DATA_W),
      .SLICE_W (SLICE_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .in_ref    (in_ref),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_count (out_count)
   );

   // Expected latency in cycles from the accept cycle t to first out_vld.
   function automatic int exp_lat(input logic [DATA_W-1:0] op);
      int k;
      k = 1;
`ifdef POPCOUNT_EARLY_EXIT_EN
      for (int s = 0; s < N; s++) begin
         if (((op >> (s * SLICE_W)) & 64'hFF) != 0) k = s + 1;
      end
      return k + 1;
`else
      k = (op == op) ? N : N;
      return k + 1;
`endif
   endfunction

   // Drive one operand at a negedge; return at the negedge after the accept
   // edge (cycle t+1) with in_vld dropped. Bounded wait for in_rdy.
   task automatic accept_op(input logic [DATA_W-1:0] data,
                            input logic [DATA_W-1:0] refw,
                            input logic mode);
      int guard;
      guard = 0;
      while (!in_rdy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      in_vld  = 1'b1;
      in_data = data;
      in_ref  = refw;
      in_mode = mode;
      @(negedge clk);
      in_vld  = 1'b0;
   endtask

   // Count cycles until out_vld; called at cycle t+1 so lat starts at 1.
   task automatic wait_result(output int lat, output logic [CNT_W-1:0] cnt);
      lat = 1;
      while (!out_vld && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      cnt = out_count;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_rdy got=%0b want=1", in_rdy);
      end
      checks++;
      if (out_vld !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_vld got=%0b want=0", out_vld);
      end
      checks++;
      if (out_count !== 7'd0) begin
         failures++;
         $display("FAIL reset_out_count got=%0d want=0", out_count);
      end
      $display("reset: in_rdy=%0b out_vld=%0b out_count=%0d", in_rdy, out_vld, out_count);
   endtask

   task automatic test_all_ones;
      int lat;
      logic [CNT_W-1:0] cnt;
      out_rdy = 1'b1;
      accept_op(64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (lat !== 9) begin
         failures++;
         $display("FAIL ones_latency got=%0d want=9", lat);
      end
      checks++;
      if (cnt !== 7'd64) begin
         failures++;
         $display("FAIL ones_count got=%0d want=64", cnt);
      end
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0) begin
         failures++;
         $display("FAIL ones_vld_one_cycle got=%0b want=0", out_vld);
      end
      checks++;
      if (in_rdy !== 1'b1 || out_count !== 7'd64) begin
         failures++;
         $display("FAIL ones_idle_hold in_rdy=%0b count=%0d want in_rdy=1 count=64", in_rdy, out_count);
      end
      $display("all_ones: latency=%0d count=%0d", lat, cnt);
   endtask

   task automatic test_hamming;
      int lat;
      logic [CNT_W-1:0] cnt;
      out_rdy = 1'b1;
      accept_op(64'h00FF, 64'h0F0F, 1'b1);
      // Change mode/reference during COUNT; must not affect the result.
      in_ref  = 64'hFFFF_FFFF_FFFF_FFFF;
      in_mode = 1'b0;
      wait_result(lat, cnt);
      checks++;
      if (cnt !== 7'd8) begin
         failures++;
         $display("FAIL hamming_count got=%0d want=8", cnt);
      end
      checks++;
      if (lat !== exp_lat(64'h0FF0)) begin
         failures++;
         $display("FAIL hamming_latency got=%0d want=%0d", lat, exp_lat(64'h0FF0));
      end
      @(negedge clk);
      $display("hamming: latency=%0d count=%0d", lat, cnt);
   endtask

   task automatic test_backpressure;
      int lat;
      logic [CNT_W-1:0] cnt;
      out_rdy = 1'b0;
      accept_op(64'hF0F0, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (cnt !== 7'd8) begin
         failures++;
         $display("FAIL bp_count got=%0d want=8", cnt);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (out_vld !== 1'b1) begin
            failures++;
            $display("FAIL bp_vld_stall cycle=%0d got=%0b want=1", c, out_vld);
         end
         checks++;
         if (out_count !== 7'd8) begin
            failures++;
            $display("FAIL bp_count_stall cycle=%0d got=%0d want=8", c, out_count);
         end
         checks++;
         if (in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_rdy_stall cycle=%0d got=%0b want=0", c, in_rdy);
         end
      end
      out_rdy = 1'b1;
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL bp_in_rdy_comb got=%0b want=1", in_rdy);
      end
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL bp_release out_vld=%0b in_rdy=%0b want 0/1", out_vld, in_rdy);
      end
      $display("backpressure: count=%0d released", cnt);
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [CNT_W-1:0] cnt;
      out_rdy = 1'b0;
      accept_op(64'hFF, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (cnt !== 7'd8) begin
         failures++;
         $display("FAIL b2b_first_count got=%0d want=8", cnt);
      end
      // Present the next operand while releasing the first result.
      in_vld  = 1'b1;
      in_data = 64'h3;
      in_mode = 1'b0;
      out_rdy = 1'b1;
      #1;
      checks++;
      if (in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_in_rdy got=%0b want=1", in_rdy);
      end
      @(negedge clk);
      in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b0 || out_count !== 7'd0) begin
         failures++;
         $display("FAIL b2b_accepted out_vld=%0b in_rdy=%0b count=%0d want 0/0/0",
                  out_vld, in_rdy, out_count);
      end
      wait_result(lat, cnt);
      checks++;
      if (cnt !== 7'd2) begin
         failures++;
         $display("FAIL b2b_second_count got=%0d want=2", cnt);
      end
      checks++;
      if (lat !== exp_lat(64'h3)) begin
         failures++;
         $display("FAIL b2b_second_latency got=%0d want=%0d", lat, exp_lat(64'h3));
      end
      @(negedge clk);
      $display("back_to_back: second latency=%0d count=%0d", lat, cnt);
   endtask

   task automatic test_reset_mid_count;
      int lat;
      int seen_vld;
      logic [CNT_W-1:0] cnt;
      out_rdy = 1'b1;
      accept_op(64'hFFFF_FFFF_FFFF_FFFF, '0, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (out_vld !== 1'b0 || out_count !== 7'd0 || in_rdy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_state out_vld=%0b count=%0d in_rdy=%0b want 0/0/1",
                  out_vld, out_count, in_rdy);
      end
      seen_vld = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (out_vld) seen_vld++;
      end
      checks++;
      if (seen_vld !== 0) begin
         failures++;
         $display("FAIL midrst_no_vld got=%0d want=0", seen_vld);
      end
      accept_op(64'h1, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (cnt !== 7'd1) begin
         failures++;
         $display("FAIL midrst_next_count got=%0d want=1", cnt);
      end
      @(negedge clk);
      $display("reset_mid_count: next count=%0d", cnt);
   endtask

   task automatic test_early_exit;
      int lat;
      int want;
      logic [CNT_W-1:0] cnt;
`ifdef POPCOUNT_EARLY_EXIT_EN
      want = 2;
`else
      want = 9;
`endif
      out_rdy = 1'b1;
      accept_op(64'h1, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (lat !== want || cnt !== 7'd1) begin
         failures++;
         $display("FAIL early_one latency=%0d count=%0d want %0d/1", lat, cnt, want);
      end
      @(negedge clk);
      accept_op('0, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (lat !== want || cnt !== 7'd0) begin
         failures++;
         $display("FAIL early_zero latency=%0d count=%0d want %0d/0", lat, cnt, want);
      end
      @(negedge clk);
      accept_op(64'h8000_0000_0000_0000, '0, 1'b0);
      wait_result(lat, cnt);
      checks++;
      if (lat !== 9 || cnt !== 7'd1) begin
         failures++;
         $display("FAIL early_top latency=%0d count=%0d want 9/1", lat, cnt);
      end
      @(negedge clk);
      $display("early_exit: expected short latency=%0d", want);
   endtask

   initial begin
      rst     = 1'b1;
      in_vld  = 1'b0;
      in_mode = 1'b0;
      in_data = '0;
      in_ref  = '0;
      out_rdy = 1'b1;
      @(negedge clk);
      test_reset;
      test_all_ones;
      test_hamming;
      test_backpressure;
      test_back_to_back;
      test_reset_mid_count;
      test_early_exit;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
